// File: rtl/multiword_add_seq_pkg.sv
// Shared types for the sequential multi-word adder.
package mwadd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mwadd_state_t;
   localparam int MAX_WORDS = 16;
endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
interface multiword_add_seq_if #(
   parameter int SLICE_W = 16,
   parameter int WORDS   = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [WORDS*SLICE_W-1:0]   in_a;
   logic [WORDS*SLICE_W-1:0]   in_b;
   logic                       in_cin;
   logic                       out_valid;
   logic                       out_ready;
   logic [WORDS*SLICE_W-1:0]   out_sum;
   logic                       out_cout;
   logic                       out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/multiword_add_seq_rca.sv
// N-bit ripple-carry adder used as the per-slice datapath.
module RippleCarryAdder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N:0] c;

   assign c[0] = cin;
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[N];
endmodule

// File: rtl/multiword_add_seq.sv
// Wide adder: latches an operand pair and runs one SLICE_W slice per clock
// through a single ripple-carry adder, LSB slice first.
module multiword_add_seq
   import mwadd_pkg::*;
#(
   parameter int SLICE_W = 16,
   parameter int WORDS   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   multiword_add_seq_if.slave bus
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   if (WORDS < 1 || WORDS > MAX_WORDS) begin : g_bad_words
      $error("multiword_add_seq: WORDS out of range");
   end

   mwadd_state_t                     state_q, state_d;
   logic [IW-1:0]                    idx_q, idx_d;
   logic                             carry_q, carry_d;
   logic [WORDS-1:0][SLICE_W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                             cout_q, cout_d, ovf_q, ovf_d;

   logic [SLICE_W-1:0]               rca_sum;
   logic                             rca_cout;
   logic                             last;

   RippleCarryAdder #(.N(SLICE_W)) u_rca (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (carry_q),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   assign last = (idx_q == IW'(WORDS - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q] = rca_sum;
            carry_d      = rca_cout;
            idx_d        = idx_q + 1'b1;
            if (last) begin
               // Signed overflow judged on the full-width operand MSBs.
               cout_d  = rca_cout;
               ovf_d   = (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1]) &&
                         (rca_sum[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed plus randomized checks of multiword_add_seq against an arithmetic reference.
module tb_multiword_add_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   multiword_add_seq_if #(.SLICE_W(16), .WORDS(4)) b4 ();
   multiword_add_seq_if #(.SLICE_W(16), .WORDS(1)) b1 ();

   multiword_add_seq #(.SLICE_W(16), .WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   multiword_add_seq #(.SLICE_W(16), .WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One 64-bit operation; hold = cycles of out_ready=0 while in DONE.
   task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input int hold, input string tag);
      logic [64:0] full;
      logic [63:0] esum;
      logic        ecout, eovf;
      int          j;
      full  = {1'b0, a} + {1'b0, b} + 65'(cin);
      esum  = full[63:0];
      ecout = full[64];
      eovf  = (a[63] == b[63]) && (esum[63] != a[63]);
      check({tag, ".in_ready_idle"}, 64'(b4.in_ready), 64'd1);
      b4.in_valid  = 1'b1;
      b4.in_a      = a;
      b4.in_b      = b;
      b4.in_cin    = cin;
      b4.out_ready = (hold == 0);
      @(negedge clk);
      b4.in_valid = 1'b0;
      b4.in_a     = {$urandom, $urandom};
      b4.in_b     = {$urandom, $urandom};
      b4.in_cin   = ~cin;
      j = 0;
      while (!b4.out_valid && j < 20) begin
         @(negedge clk);
         j++;
      end
      check({tag, ".latency"}, 64'(j), 64'd4);
      check({tag, ".sum"}, b4.out_sum, esum);
      check({tag, ".cout"}, 64'(b4.out_cout), 64'(ecout));
      check({tag, ".ovf"}, 64'(b4.out_ovf), 64'(eovf));
      for (int h = 0; h < hold; h++) begin
         b4.in_valid = 1'b1;
         b4.in_a     = {$urandom, $urandom};
         b4.in_b     = {$urandom, $urandom};
         @(negedge clk);
         check({tag, ".bp_in_ready"}, 64'(b4.in_ready), 64'd0);
         check({tag, ".bp_valid"}, 64'(b4.out_valid), 64'd1);
         check({tag, ".bp_sum"}, b4.out_sum, esum);
      end
      b4.in_valid  = 1'b0;
      b4.out_ready = 1'b1;
      @(negedge clk);
      b4.out_ready = 1'b0;
      check({tag, ".post_valid"}, 64'(b4.out_valid), 64'd0);
      check({tag, ".post_in_ready"}, 64'(b4.in_ready), 64'd1);
      check({tag, ".post_sum_kept"}, b4.out_sum, esum);
   endtask

   task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input string tag);
      logic [16:0] full;
      int          j;
      full = {1'b0, a} + {1'b0, b} + 17'(cin);
      check({tag, ".in_ready_idle"}, 64'(b1.in_ready), 64'd1);
      b1.in_valid  = 1'b1;
      b1.in_a      = a;
      b1.in_b      = b;
      b1.in_cin    = cin;
      b1.out_ready = 1'b1;
      @(negedge clk);
      b1.in_valid = 1'b0;
      b1.in_a     = 16'($urandom);
      j = 0;
      while (!b1.out_valid && j < 20) begin
         @(negedge clk);
         j++;
      end
      check({tag, ".latency"}, 64'(j), 64'd1);
      check({tag, ".sum"}, 64'(b1.out_sum), 64'(full[15:0]));
      check({tag, ".cout"}, 64'(b1.out_cout), 64'(full[16]));
      check({tag, ".ovf"}, 64'(b1.out_ovf),
            64'((a[15] == b[15]) && (full[15] != a[15])));
      @(negedge clk);
      b1.out_ready = 1'b0;
      check({tag, ".post_valid"}, 64'(b1.out_valid), 64'd0);
   endtask

   initial begin
      b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_cin = 1'b0; b4.out_ready = 1'b0;
      b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_cin = 1'b0; b1.out_ready = 1'b0;
      #12;
      check("rst.in_ready", 64'(b4.in_ready), 64'd1);
      check("rst.out_valid", 64'(b4.out_valid), 64'd0);
      check("rst.out_sum", b4.out_sum, 64'd0);
      check("rst.cout_ovf", {62'd0, b4.out_cout, b4.out_ovf}, 64'd0);
      check("rst.w1_sum", 64'(b1.out_sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      op4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, "wrap");
      op4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, "ovf");
      op4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 0, "chain");
      op4(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 5, "bp");
      check("bp.sum_value", b4.out_sum, 64'h0001_0000_0001_0000);

      // Abort after two RUN cycles.
      b4.in_valid = 1'b1;
      b4.in_a     = 64'hDEAD_BEEF_CAFE_F00D;
      b4.in_b     = 64'h1111_2222_3333_4444;
      b4.in_cin   = 1'b0;
      @(negedge clk);
      b4.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort.out_valid", 64'(b4.out_valid), 64'd0);
      check("abort.out_sum", b4.out_sum, 64'd0);
      check("abort.in_ready", 64'(b4.in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 0, "after_rst");
      check("after_rst.value", b4.out_sum, 64'h2222_2222_2222_2212);

      for (int i = 0; i < 16; i++) begin
         logic [63:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 4 == 1) ra[63] = rb[63];
         op4(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      op1(16'hFFFF, 16'h0001, 1'b1, "w1");
      check("w1.value", 64'(b1.out_sum), 64'h0001);
      for (int i = 0; i < 6; i++)
         op1(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("w1rnd%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Sequential wide-operand adder built around the team's 16-bit ripple-carry adder (RippleCarryAdder, N=SLICE_W).
- Accepts a WORDS*SLICE_W-bit operand pair over a valid/ready handshake.
- Adds one SLICE_W-bit slice per clock, LSB slice first, feeding each slice's carry-out into the next slice's carry-in.
- Presents the full sum, carry-out and signed overflow over a valid/ready output handshake.
- Sits directly upstream of the slice adder and also consumes its outputs; it is the operand feeder/result collector for that adder.

Parameters:
SLICE_W, 16, width of one slice; passed to the slice adder as N.
WORDS, 4, number of slices per operand; legal range 1..16.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair present.
in_ready  out  1  block can accept operands.
in_a  in  WORDS*SLICE_W  operand A.
in_b  in  WORDS*SLICE_W  operand B.
in_cin  in  1  carry-in to slice 0.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts result.
out_sum  out  WORDS*SLICE_W  sum, modulo 2^(WORDS*SLICE_W).
out_cout  out  1  carry out of the MSB slice.
out_ovf  out  1  two's-complement signed overflow.

Behaviour:
Reset values:
- rst_n low asynchronously forces state=IDLE, slice index=0 and carry=0.
- Operand registers and out_sum are forced to 0; out_cout, out_ovf and out_valid are forced to 0.
- While in IDLE, in_ready=1.

State IDLE:
- in_ready=1 and out_valid=0.
- On in_valid&&in_ready at edge T:
  - latch in_a, in_b and in_cin;
  - set idx=0 and carry=in_cin;
  - go to RUN.
- After acceptance, input changes have no effect.

State RUN:
- in_ready=0 and out_valid=0.
- Each edge:
  - slice adder gets A[idx], B[idx] and carry;
  - its sum is written to sum slice idx;
  - carry takes its cout;
  - idx increments.
- On the edge processing idx==WORDS-1:
  - out_cout is set to the adder cout;
  - out_ovf is set to (A_msb==B_msb)&&(sum_msb!=A_msb), where msb is the top bit of the full operand;
  - go to DONE.
- With WORDS=1, RUN lasts exactly one cycle.

State DONE:
- out_valid=1 and in_ready=0.
- out_sum, out_cout and out_ovf are held stable until out_valid&&out_ready.
- On that handshake edge go to IDLE; out_valid drops the next cycle and in_ready rises the next cycle.
- Result registers keep their last value after the handshake; they are not cleared.

Latency and throughput:
- Acceptance at edge T: out_valid is high from edge T+WORDS.
- With out_ready held high, the handshake completes at edge T+WORDS+1.
- No input/output overlap; max throughput is one operation per WORDS+2 cycles.

Boundary conditions:
- in_valid while busy is ignored (in_ready=0); the upstream must hold its data.
- out_ready while out_valid=0 is ignored.
- All-ones + 1 wraps to 0 with out_cout=1.
- Reset asserted mid-RUN or mid-DONE aborts the operation and the partial result is discarded.
- The first accept after rst_n release behaves exactly as from power-up.
- Arithmetic is unsigned modulo 2^(WORDS*SLICE_W); out_ovf is an informational signed interpretation only.

Decomposition:
- Package mwadd_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mwadd_state_t;
  - localparam MAX_WORDS=16.
- Index width is derived locally as $clog2(WORDS) with a minimum of 1.
- One sub-module: the existing RippleCarryAdder, instantiated once with N=SLICE_W.
- Slice muxing, result write-back and the FSM are in this block.

Test Plan:
Defaults for all scenarios: SLICE_W=16, WORDS=4.
1. A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0, out_ready=1 → sum=0, cout=1, ovf=0. out_valid rises exactly 4 edges after the accept edge.
2. A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
3. A=0x1234_5678_9ABC_DEF0, B=0x0FED_CBA9_8765_4321, cin=1 → sum=0x2222_2222_2222_2212, cout=0, ovf=0. This checks the inter-slice carry chain.
4. Backpressure, using A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001:
   - hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands;
   - required: sum=0x0001_0000_0001_0000 stays stable, in_ready=0, new operands ignored;
   - after the handshake, in_ready=1 the next cycle.
5. Assert rst_n low after 2 RUN cycles:
   - immediately out_valid=0, out_sum=0, in_ready=1;
   - after release, scenario 3 yields the correct result.
6. WORDS=1 build, A=0xFFFF, B=0x0001, cin=1 → sum=0x0001, cout=1, ovf=0. out_valid rises 1 edge after accept.
